// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port image SRAM; port A reads, port B reads/writes.
// Optional ARB_STATS_EN adds saturating contention / A-grant counters.
module sram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       a_gnt_cnt
`endif
);

    // state   | meaning
    // IDLE    | no grant last cycle
    // OWN_A   | last grant went to A
    // OWN_B   | last grant went to B
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t            state_q, state_d;
    logic              last_b_q;
    logic [3:0]        hold_q, hold_d;
    logic              s1_valid_q, s1_b_q, s2_valid_q, s2_b_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              both_req;

    assign both_req = a_req && b_req;

    // Grants are suppressed while reset is asserted so no request is consumed.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        state_d = IDLE;
        hold_d  = 4'd0;
        if (rst_n) begin
            if (a_req && !b_req) begin
                a_gnt = 1'b1;
            end else if (b_req && !a_req) begin
                b_gnt = 1'b1;
            end else if (both_req) begin
                case (state_q)
                    OWN_A: begin
                        if (hold_q < MAX_HOLD_C) a_gnt = 1'b1;
                        else                     b_gnt = 1'b1;
                    end
                    OWN_B: begin
                        if (hold_q < MAX_HOLD_C) b_gnt = 1'b1;
                        else                     a_gnt = 1'b1;
                    end
                    default: begin
                        if (last_b_q) a_gnt = 1'b1;
                        else          b_gnt = 1'b1;
                    end
                endcase
            end
        end
        if (a_gnt)      state_d = OWN_A;
        else if (b_gnt) state_d = OWN_B;
        if ((a_gnt || b_gnt) && both_req) begin
            if ((a_gnt && state_q == OWN_A) || (b_gnt && state_q == OWN_B))
                hold_d = hold_q + 4'd1;
            else
                hold_d = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            hold_q     <= 4'd0;
            sram_en    <= 1'b0;
            sram_wen   <= 1'b1;
            sram_addr  <= '0;
            sram_d     <= '0;
            s1_valid_q <= 1'b0;
            s1_b_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_b_q     <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (a_gnt)      last_b_q <= 1'b0;
            else if (b_gnt) last_b_q <= 1'b1;

            sram_en  <= a_gnt || b_gnt;
            sram_wen <= !(b_gnt && b_we);
            if (a_gnt) begin
                sram_addr <= a_addr;
                sram_d    <= '0;
            end else if (b_gnt) begin
                sram_addr <= b_addr;
                sram_d    <= b_we ? b_wdata : '0;
            end

            // Tag follows the read through the SRAM's register + access stages.
            s1_valid_q <= a_gnt || (b_gnt && !b_we);
            s1_b_q     <= b_gnt;
            s2_valid_q <= s1_valid_q;
            s2_b_q     <= s1_b_q;

            a_rdata_q <= a_rdata;
            b_rdata_q <= b_rdata;
        end
    end

    assign a_rvalid = s2_valid_q && !s2_b_q;
    assign b_rvalid = s2_valid_q &&  s2_b_q;
    assign a_rdata  = a_rvalid ? sram_q : a_rdata_q;
    assign b_rdata  = b_rvalid ? sram_q : b_rdata_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
            a_gnt_cnt    <= 16'd0;
        end else begin
            if (both_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            if (a_gnt && a_gnt_cnt != 16'hFFFF)       a_gnt_cnt    <= a_gnt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 64K x 8 SRAM model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_gnt, a_rvalid;
    logic [15:0] a_addr;
    logic [7:0]  a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata, b_rdata;
    logic        sram_en, sram_wen;
    logic [15:0] sram_addr;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q = 8'h00;
`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt, a_gnt_cnt;
`endif

    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          fails = 0;

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
        .sram_q(sram_q)
`ifdef ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .a_gnt_cnt(a_gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    32'(sram_en),   32'd0);
        check({tag, "_wen"},   32'(sram_wen),  32'd1);
        check({tag, "_addr"},  32'(sram_addr), 32'd0);
        check({tag, "_d"},     32'(sram_d),    32'd0);
        check({tag, "_arv"},   32'(a_rvalid),  32'd0);
        check({tag, "_brv"},   32'(b_rvalid),  32'd0);
        check({tag, "_ardat"}, 32'(a_rdata),   32'd0);
        check({tag, "_brdat"}, 32'(b_rdata),   32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0102] = 8'h5A;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);

        rst_n = 1'b0; a_req = 1'b1; a_addr = 16'h0000;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0010; b_wdata = 8'h00;

        // Reset held two cycles with both ports requesting
        tick(); tick();
        check_reset_outputs("rst");
        check("rst_agnt", 32'(a_gnt), 32'd0);
        check("rst_bgnt", 32'(b_gnt), 32'd0);

        // Continuous contention from reset: A x4, B x4, A...
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("cont_agnt%0d", i), 32'(a_gnt), 32'((i < 4) || (i >= 8)));
            check($sformatf("cont_bgnt%0d", i), 32'(b_gnt), 32'((i >= 4) && (i < 8)));
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick(); tick(); tick();
        check("drain_en",  32'(sram_en),  32'd0);
        check("drain_arv", 32'(a_rvalid), 32'd0);
        check("drain_brv", 32'(b_rvalid), 32'd0);

        // Single A read of 0x0102
        a_req = 1'b1; a_addr = 16'h0102;
        #1;
        check("rd_agnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 1'b0;
        check("rd_en",   32'(sram_en),   32'd1);
        check("rd_addr", 32'(sram_addr), 32'h0102);
        check("rd_wen",  32'(sram_wen),  32'd1);
        check("rd_arv1", 32'(a_rvalid),  32'd0);
        tick();
        check("rd_arv2", 32'(a_rvalid), 32'd1);
        check("rd_data", 32'(a_rdata),  32'h5A);
        check("rd_brv2", 32'(b_rvalid), 32'd0);
        tick();
        check("rd_arv3",  32'(a_rvalid), 32'd0);
        check("rd_hold",  32'(a_rdata),  32'h5A);

        // B writes 0x3C to 0xFFFF, A reads it back next cycle
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'hFFFF; b_wdata = 8'h3C;
        #1;
        check("wr_bgnt", 32'(b_gnt), 32'd1);
        tick();
        b_req = 1'b0; b_we = 1'b0;
        a_req = 1'b1; a_addr = 16'hFFFF;
        #1;
        check("wr_en",   32'(sram_en),   32'd1);
        check("wr_wen",  32'(sram_wen),  32'd0);
        check("wr_d",    32'(sram_d),    32'h3C);
        check("wr_addr", 32'(sram_addr), 32'hFFFF);
        check("wr_agnt", 32'(a_gnt),     32'd1);
        tick();
        a_req = 1'b0;
        check("wr_wen2", 32'(sram_wen), 32'd1);
        check("wr_brv",  32'(b_rvalid), 32'd0);
        check("wr_arv",  32'(a_rvalid), 32'd0);
        tick();
        check("raw_arv",  32'(a_rvalid), 32'd1);
        check("raw_data", 32'(a_rdata),  32'h3C);
        check("raw_brv",  32'(b_rvalid), 32'd0);
        tick();

        // B read of 0x0102 returns on the B side only
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0102;
        #1;
        check("brd_bgnt", 32'(b_gnt), 32'd1);
        tick();
        b_req = 1'b0;
        tick();
        check("brd_brv",   32'(b_rvalid), 32'd1);
        check("brd_data",  32'(b_rdata),  32'h5A);
        check("brd_arv",   32'(a_rvalid), 32'd0);
        check("brd_ahold", 32'(a_rdata),  32'h3C);
        tick();

        // A reads 0..7 back-to-back
        for (int k = 0; k < 11; k++) begin
            a_req  = (k < 8);
            a_addr = 16'(k);
            #1;
            if (k < 8) check($sformatf("pipe_gnt%0d", k), 32'(a_gnt), 32'd1);
            check($sformatf("pipe_rv%0d", k), 32'(a_rvalid), 32'((k >= 2) && (k < 10)));
            if (k >= 2 && k < 10)
                check($sformatf("pipe_dat%0d", k), 32'(a_rdata), 32'(8'h10 + k - 2));
            tick();
        end
        a_req = 1'b0;

        // Reset one cycle after an A grant drops the read
        a_req = 1'b1; a_addr = 16'h0102;
        #1;
        check("mrst_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_req = 1'b0; rst_n = 1'b0;
        tick();
        check_reset_outputs("mrst");
        rst_n = 1'b1;
        tick();
        check("mrst_arv_after", 32'(a_rvalid), 32'd0);
        check("mrst_en_after",  32'(sram_en),  32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port 64K x 8 image SRAM between two requesters.
  - Port A: convolution filter. Read-only.
  - Port B: host image loader/checker. Read or write.
- Round-robin arbitration with a bounded hold window.
- Registers all SRAM-side signals and routes read data back to the issuing port with a matching valid pulse.
- Sits between the filter/host and the SRAM macro, replacing the filter's direct tie to the SRAM.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 8, SRAM data width.
- MAX_HOLD, 4, maximum consecutive grants to one port while the other port is requesting (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_req  in  1  filter read request
- a_addr  in  ADDR_W  filter read address
- a_gnt  out  1  filter request accepted this cycle (combinational)
- a_rvalid  out  1  a_rdata valid
- a_rdata  out  DATA_W  filter read data
- b_req  in  1  host request
- b_we  in  1  host request is a write when 1
- b_addr  in  ADDR_W  host address
- b_wdata  in  DATA_W  host write data
- b_gnt  out  1  host request accepted this cycle (combinational)
- b_rvalid  out  1  b_rdata valid (reads only)
- b_rdata  out  DATA_W  host read data
- sram_en  out  1  SRAM enable (registered)
- sram_wen  out  1  SRAM write enable, active-low: 0 = write, 1 = read (registered)
- sram_addr  out  ADDR_W  SRAM address (registered)
- sram_d  out  DATA_W  SRAM write data (registered)
- sram_q  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - sram_en=0, sram_wen=1, sram_addr=0, sram_d=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - last_owner=B, hold_cnt=0, state=IDLE, read pipeline flushed.
- Reset mid-operation: in-flight reads are dropped; no rvalid is issued for them.
- States:
  - IDLE: no grant last cycle.
  - OWN_A: last grant went to A.
  - OWN_B: last grant went to B.
- Grant rule, evaluated combinationally each cycle; at most one of a_gnt/b_gnt is high:
  - Only one port requesting -> that port is granted.
  - Both requesting from IDLE -> grant the port that is not last_owner (first contention after reset goes to A).
  - Both requesting from OWN_x with hold_cnt < MAX_HOLD -> keep x.
  - Both requesting from OWN_x with hold_cnt == MAX_HOLD -> switch to the other port.
  - No request -> no grant; next state IDLE; hold_cnt=0.
- hold_cnt:
  - Increments on each grant to the current owner while the other port is requesting.
  - Resets to 1 on an owner switch.
  - Resets to 0 when the other port is not requesting.
- At the clk edge of a granted cycle, the SRAM side registers:
  - sram_en=1.
  - sram_addr = granted address.
  - sram_wen = 0 for a B write, else 1.
  - sram_d = b_wdata for a B write, else 0.
- With no grant: sram_en=0, sram_wen=1; sram_addr and sram_d hold their values.
- Read return:
  - A 2-stage tag pipeline (valid + port id) follows each read.
  - Grant in cycle T -> SRAM samples at the end of T+1 -> sram_q is valid in T+2.
  - In T+2, x_rvalid=1 and x_rdata=sram_q for the issuing port x.
  - Latency is exactly 2 cycles.
  - Back-to-back reads return back-to-back.
- Writes produce no rvalid.
- Requesters hold req, addr, we and wdata stable until they see gnt. A request is consumed only in a cycle where its gnt is high.
- x_rdata holds its last value when x_rvalid=0.
- Simultaneous events:
  - A B write to address X granted in cycle T followed by an A read of X granted in T+1 returns the new data. The ordering is guaranteed by the single SRAM port.
- Address wrap: none. Addresses pass through unmodified; 16'hFFFF is legal.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds output ports:
  - conflict_cnt [15:0]: cycles with a_req && b_req.
  - a_gnt_cnt [15:0]: total A grants.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with a_req=b_req=1 -> sram_en=0, sram_wen=1, no gnt effect on the SRAM side, a_rvalid=b_rvalid=0.
- Single A read: a_addr=16'h0102 for 1 cycle, SRAM preloaded 0x5A -> a_gnt in T; sram_en=1 and sram_addr=0x0102 in T+1; a_rvalid=1 and a_rdata=0x5A in T+2.
- Write then read: B writes 0x3C to 16'hFFFF, then A reads 16'hFFFF -> sram_wen=0 and sram_d=0x3C in the write cycle; a_rdata=0x3C two cycles after a_gnt.
- Contention with MAX_HOLD=4: both ports request continuously from reset -> grant pattern A,A,A,A,B,B,B,B,A,...; no cycle with both gnts high.
- Pipelined reads: A reads addresses 0..7 on consecutive cycles -> 8 consecutive a_rvalid pulses with data in order, starting 2 cycles after the first grant.
- Mid-operation reset: assert rst_n=0 one cycle after an A grant -> no a_rvalid for that read; all outputs at reset values.
